cond_sched: RTL and testbench

COND_SCHED -- requirements
Module: cond_sched

---
 rtl/cond_sched_if.sv | 42 ++++
 rtl/cond_sched.sv | 127 ++++++++++++
 tb/tb_cond_sched.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_sched_if.sv
// Handshake bundle between a CGRA condition producer/consumer and cond_sched.
// The master side drives the window request and per-PE condition strobes and
// consumes the result; the slave side is the scheduler itself.
interface cond_sched_if #(
    parameter int NB_PE = 16
) ();

    logic             Start;
    logic [NB_PE-1:0] Cond_Mask;
    logic [NB_PE-1:0] In_Cond;
    logic [NB_PE-1:0] In_Cond_Valid;
    logic             Out_Cond;
    logic             Out_Valid;
    logic             Out_Ready;
    logic             Timeout_Err;
    logic             Busy;

    modport master (
        output Start,
        output Cond_Mask,
        output In_Cond,
        output In_Cond_Valid,
        output Out_Ready,
        input  Out_Cond,
        input  Out_Valid,
        input  Timeout_Err,
        input  Busy
    );

    modport slave (
        input  Start,
        input  Cond_Mask,
        input  In_Cond,
        input  In_Cond_Valid,
        input  Out_Ready,
        output Out_Cond,
        output Out_Valid,
        output Timeout_Err,
        output Busy
    );

endinterface

// File: rtl/cond_sched.sv
// Condition-window scheduler for a CGRA: opens a window over a set of PEs,
// ORs together the first condition reported by each participating PE, and
// closes on completion (all reported) or after TIMEOUT collection cycles.
module cond_sched #(
    parameter int NB_ROWS = 4,
    parameter int NB_COLS = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    cond_sched_if.slave bus
);

    localparam int NB_PE = NB_ROWS * NB_COLS;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Counter starts at 0 on the first COLLECT cycle, so this value marks the
    // TIMEOUT-th collection cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [NB_PE-1:0] r_pending;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out_cond;
    logic             r_out_valid;
    logic             r_timeout_err;
    logic             r_busy;

    logic [NB_PE-1:0] w_accept;
    logic [NB_PE-1:0] w_pending_nxt;
    logic             w_acc_nxt;

    // Same-cycle update of the pending set and accumulator: only PEs still
    // pending may contribute, so repeat or unmasked strobes fall away here.
    always_comb begin
        w_accept      = bus.In_Cond_Valid & r_pending;
        w_pending_nxt = r_pending & ~w_accept;
        w_acc_nxt     = r_acc | (|(w_accept & bus.In_Cond));
    end

    // Window FSM with registered result/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pending     <= '0;
            r_acc         <= 1'b0;
            r_cnt         <= '0;
            r_out_cond    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_pending <= bus.Cond_Mask;
                        r_acc     <= 1'b0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        if (bus.Cond_Mask == '0) begin
                            r_state       <= S_DONE;
                            r_out_valid   <= 1'b1;
                            r_out_cond    <= 1'b0;
                            r_timeout_err <= 1'b0;
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end

                S_COLLECT: begin
                    r_pending <= w_pending_nxt;
                    r_acc     <= w_acc_nxt;
                    r_cnt     <= r_cnt + 1'b1;
                    // Completion is tested first so it wins over a coincident timeout.
                    if (w_pending_nxt == '0) begin
                        r_state       <= S_DONE;
                        r_out_valid   <= 1'b1;
                        r_out_cond    <= w_acc_nxt;
                        r_timeout_err <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= S_DONE;
                        r_out_valid   <= 1'b1;
                        r_out_cond    <= w_acc_nxt;
                        r_timeout_err <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (bus.Out_Ready) begin
                        r_state       <= S_IDLE;
                        r_pending     <= '0;
                        r_acc         <= 1'b0;
                        r_cnt         <= '0;
                        r_out_cond    <= 1'b0;
                        r_out_valid   <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_busy        <= 1'b0;
                    end
                end

                default: begin
                    r_state       <= S_IDLE;
                    r_pending     <= '0;
                    r_acc         <= 1'b0;
                    r_cnt         <= '0;
                    r_out_cond    <= 1'b0;
                    r_out_valid   <= 1'b0;
                    r_timeout_err <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Out_Cond    = r_out_cond;
    assign bus.Out_Valid   = r_out_valid;
    assign bus.Timeout_Err = r_timeout_err;
    assign bus.Busy        = r_busy;

endmodule

// File: tb/tb_cond_sched.sv
// Self-checking bench for cond_sched (4x4 PEs, TIMEOUT=4): directed windows
// from the requirement list plus randomized windows against a per-PE
// first-report reference model.
module tb_cond_sched;

    localparam int TO    = 4;
    localparam int NPE   = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-COLLECT-cycle stimulus for the current window.
    logic [NPE-1:0] sv [TO];
    logic [NPE-1:0] sc [TO];

    cond_sched_if #(.NB_PE(NPE)) bus ();

    cond_sched #(
        .NB_ROWS(4),
        .NB_COLS(4),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each participating PE contributes the condition from its
    // first valid cycle; the window ends one cycle after the latest first
    // report, or at TO with a timeout if any PE never reports.
    task automatic model(input logic [NPE-1:0] mask, output int done_at,
                         output logic ecnd, output logic eterr);
        int  first;
        int  last;
        bit  all;
        ecnd  = 1'b0;
        eterr = 1'b0;
        last  = 0;
        all   = 1'b1;
        if (mask == '0) begin
            done_at = 0;
            return;
        end
        for (int i = 0; i < NPE; i++) begin
            if (mask[i]) begin
                first = -1;
                for (int k = 0; k < TO; k++)
                    if (first < 0 && sv[k][i]) first = k;
                if (first < 0) all = 1'b0;
                else begin
                    ecnd = ecnd | sc[first][i];
                    if (first + 1 > last) last = first + 1;
                end
            end
        end
        if (all) done_at = last;
        else begin
            done_at = TO;
            eterr   = 1'b1;
        end
    endtask

    task automatic run_window(input logic [NPE-1:0] mask, input int hold,
                              input bit noise, input string tag);
        int   d;
        logic ec, et;
        logic [NPE-1:0] tmp;
        model(mask, d, ec, et);

        // Idle cycle with stray strobes must not start anything.
        bus.Start         = 1'b0;
        bus.Out_Ready     = 1'b0;
        bus.In_Cond_Valid = noise ? NPE'($urandom) : '0;
        bus.In_Cond       = NPE'($urandom);
        tick();
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Out_Valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: Busy=%0b Out_Valid=%0b expected 0/0", tag, bus.Busy, bus.Out_Valid);
        end

        bus.Start         = 1'b1;
        bus.Cond_Mask     = mask;
        bus.In_Cond_Valid = '0;
        tick();
        bus.Start     = 1'b0;
        bus.Cond_Mask = NPE'($urandom);

        for (int c = 0; c < d; c++) begin
            n_checks++;
            if (bus.Out_Valid !== 1'b0 || bus.Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s collect%0d: Out_Valid=%0b Busy=%0b expected 0/1", tag, c, bus.Out_Valid, bus.Busy);
            end
            bus.In_Cond_Valid = sv[c];
            bus.In_Cond       = sc[c];
            if (noise) begin
                bus.Start = 1'($urandom_range(0, 1));
                tmp = NPE'($urandom);
                bus.Cond_Mask = tmp;
            end
            tick();
        end
        bus.Start         = 1'b0;
        bus.In_Cond_Valid = noise ? NPE'($urandom) : '0;
        bus.In_Cond       = NPE'($urandom);

        n_checks++;
        if (bus.Out_Valid !== 1'b1 || bus.Out_Cond !== ec || bus.Timeout_Err !== et || bus.Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s result: valid=%0b cond=%0b terr=%0b busy=%0b expected 1/%0b/%0b/1",
                     tag, bus.Out_Valid, bus.Out_Cond, bus.Timeout_Err, bus.Busy, ec, et);
        end

        for (int h = 0; h < hold; h++) begin
            bus.Start         = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.In_Cond_Valid = noise ? NPE'($urandom) : '0;
            bus.In_Cond       = NPE'($urandom);
            tick();
            n_checks++;
            if (bus.Out_Valid !== 1'b1 || bus.Out_Cond !== ec || bus.Timeout_Err !== et) begin
                n_fail++;
                $display("FAIL %s hold%0d: valid=%0b cond=%0b terr=%0b expected 1/%0b/%0b",
                         tag, h, bus.Out_Valid, bus.Out_Cond, bus.Timeout_Err, ec, et);
            end
        end

        // Handshake; a Start in the same cycle must be ignored.
        bus.Out_Ready = 1'b1;
        bus.Start     = noise ? 1'b1 : 1'b0;
        bus.Cond_Mask = '1;
        tick();
        bus.Out_Ready     = 1'b0;
        bus.Start         = 1'b0;
        bus.In_Cond_Valid = '0;
        n_checks++;
        if (bus.Busy !== 1'b0 || bus.Out_Valid !== 1'b0 || bus.Out_Cond !== 1'b0 || bus.Timeout_Err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s release: busy=%0b valid=%0b cond=%0b terr=%0b expected all 0",
                     tag, bus.Busy, bus.Out_Valid, bus.Out_Cond, bus.Timeout_Err);
        end
        tick();
        n_checks++;
        if (bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s post_release: Busy=%0b expected 0", tag, bus.Busy);
        end
    endtask

    task automatic set_stim(input logic [NPE-1:0] v0, v1, v2, v3,
                            input logic [NPE-1:0] c0, c1, c2, c3);
        sv[0] = v0; sv[1] = v1; sv[2] = v2; sv[3] = v3;
        sc[0] = c0; sc[1] = c1; sc[2] = c2; sc[3] = c3;
    endtask

    task automatic test_reset();
        bus.Start         = 1'b0;
        bus.Cond_Mask     = '0;
        bus.In_Cond       = '0;
        bus.In_Cond_Valid = '0;
        bus.Out_Ready     = 1'b0;
        rst = 1'b1;
        #13;
        n_checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Cond !== 1'b0 || bus.Timeout_Err !== 1'b0 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: valid=%0b cond=%0b terr=%0b busy=%0b expected all 0",
                     bus.Out_Valid, bus.Out_Cond, bus.Timeout_Err, bus.Busy);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_first_cycle();
        set_stim(16'h000F, 16'h0, 16'h0, 16'h0, 16'h0004, 16'h0, 16'h0, 16'h0);
        run_window(16'h000F, 0, 1'b0, "all_first");
    endtask

    task automatic test_first_report_only();
        set_stim(16'h0001, 16'h0001, 16'h0002, 16'h0, 16'h0, 16'h0001, 16'h0, 16'h0);
        run_window(16'h0003, 1, 1'b0, "first_only");
    endtask

    task automatic test_timeout();
        set_stim(16'h0002, 16'h0, 16'h0, 16'h0, 16'h0002, 16'h0, 16'h0, 16'h0);
        run_window(16'h0003, 1, 1'b0, "timeout");
    endtask

    task automatic test_complete_at_limit();
        set_stim(16'h0001, 16'h0, 16'h0, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0002);
        run_window(16'h0003, 1, 1'b0, "limit_complete");
    endtask

    task automatic test_empty_mask_hold();
        set_stim('0, '0, '0, '0, '0, '0, '0, '0);
        run_window(16'h0000, 10, 1'b1, "empty_hold");
    endtask

    task automatic test_reset_mid_window(input bit in_done);
        bus.Start     = 1'b1;
        bus.Cond_Mask = 16'h00F0;
        tick();
        bus.Start         = 1'b0;
        bus.In_Cond_Valid = in_done ? 16'h00F0 : 16'h0010;
        bus.In_Cond       = 16'h00F0;
        tick();
        bus.In_Cond_Valid = '0;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Cond !== 1'b0 || bus.Timeout_Err !== 1'b0 || bus.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid%0b: valid=%0b cond=%0b terr=%0b busy=%0b expected all 0",
                     in_done, bus.Out_Valid, bus.Out_Cond, bus.Timeout_Err, bus.Busy);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.In_Cond_Valid = NPE'($urandom);
            bus.In_Cond       = NPE'($urandom);
            tick();
            n_checks++;
            if (bus.Out_Valid !== 1'b0 || bus.Busy !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_after%0b_%0d: valid=%0b busy=%0b expected 0/0", in_done, k, bus.Out_Valid, bus.Busy);
            end
        end
        bus.In_Cond_Valid = '0;
        set_stim(16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0);
        run_window(16'h0100, 0, 1'b0, "after_reset");
    endtask

    task automatic test_random(input int n);
        logic [NPE-1:0] mask;
        for (int w = 0; w < n; w++) begin
            case ($urandom_range(0, 3))
                0: mask = '0;
                1: mask = NPE'($urandom) & NPE'($urandom) & NPE'($urandom);
                2: mask = NPE'(1) << $urandom_range(0, NPE - 1);
                default: mask = NPE'($urandom) & NPE'($urandom);
            endcase
            for (int k = 0; k < TO; k++) begin
                sv[k] = $urandom_range(0, 1) ? NPE'($urandom) : (NPE'($urandom) & NPE'($urandom));
                sc[k] = NPE'($urandom) & NPE'($urandom) & NPE'($urandom);
            end
            run_window(mask, $urandom_range(0, 3), 1'b1, $sformatf("rand%0d", w));
        end
    endtask

    initial begin
        test_reset();
        test_all_first_cycle();
        test_first_report_only();
        test_timeout();
        test_complete_at_limit();
        test_empty_mask_hold();
        test_reset_mid_window(1'b0);
        test_reset_mid_window(1'b1);
        test_random(60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
